// File: rtl/imm_gen_pipe.sv
// Registered ARM64 immediate generator (I/D/B/CB/IW) with valid/ready output and optional 2-entry skid.
// Optional macro IMM_GEN_PC_TARGET_EN adds a pc input and a registered branch-target output tgt_out.
module imm_gen_pipe #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned SKID   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr,
    input  logic [2:0]        fmt,
`ifdef IMM_GEN_PC_TARGET_EN
    input  logic [63:0]       pc,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] imm_out,
    output logic              imm_err
`ifdef IMM_GEN_PC_TARGET_EN
    ,
    output logic [DATA_W-1:0] tgt_out
`endif
);

`ifdef IMM_GEN_PC_TARGET_EN
    localparam int unsigned PAY_W = 2 * DATA_W + 1;
`else
    localparam int unsigned PAY_W = DATA_W + 1;
`endif

    logic [63:0]       imm64;
    logic              err_c;
    logic [5:0]        iw_sh;
    logic [DATA_W-1:0] imm_c;
    logic [PAY_W-1:0]  new_pay;

    logic             main_v, main_v_n;
    logic             skid_v, skid_v_n;
    logic             rdy_q;
    logic [PAY_W-1:0] main_pay, main_pay_n;
    logic [PAY_W-1:0] skid_pay, skid_pay_n;
    logic             in_xfer, out_xfer;

    // Immediate decode, built at 64 bits; truncation to DATA_W matches extend-to-DATA_W-then-shift.
    always_comb begin
        imm64 = '0;
        err_c = 1'b0;
        iw_sh = {instr[22:21], 4'b0000};
        case (fmt)
            3'd0: imm64 = instr[22] ? {40'b0, instr[21:10], 12'b0} : {52'b0, instr[21:10]};
            3'd1: imm64 = {{55{instr[20]}}, instr[20:12]};
            3'd2: imm64 = {{36{instr[25]}}, instr[25:0], 2'b00};
            3'd3: imm64 = {{43{instr[23]}}, instr[23:5], 2'b00};
            3'd4: begin
                if (DATA_W == 32 && instr[22]) begin
                    err_c = 1'b1;
                end else begin
                    imm64 = {48'b0, instr[20:5]} << iw_sh;
                end
            end
            default: err_c = 1'b1;
        endcase
    end

    assign imm_c = imm64[DATA_W-1:0];

`ifdef IMM_GEN_PC_TARGET_EN
    logic [63:0]       tgt64;
    logic [DATA_W-1:0] tgt_c;
    logic              unused_tgt;

    // Only the low DATA_W bits of the sum matter, so the 64-bit add is exact modulo 2^DATA_W.
    assign tgt64      = pc + imm64;
    assign tgt_c      = (fmt == 3'd2 || fmt == 3'd3) ? tgt64[DATA_W-1:0] : '0;
    assign new_pay    = {tgt_c, err_c, imm_c};
    assign unused_tgt = ^tgt64;
    assign tgt_out    = main_pay[2*DATA_W:DATA_W+1];
`else
    assign new_pay = {err_c, imm_c};
`endif

    logic unused_bits;
    assign unused_bits = ^{instr[31:26], instr[4:0], imm64};

    assign in_ready  = (SKID != 0) ? rdy_q : (!main_v || out_ready);
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = main_v && out_ready;
    assign out_valid = main_v;
    assign imm_out   = main_pay[DATA_W-1:0];
    assign imm_err   = main_pay[DATA_W];

    // Next-state for the main/skid entries; flush kills everything including this cycle's input.
    always_comb begin
        main_v_n   = main_v;
        skid_v_n   = skid_v;
        main_pay_n = main_pay;
        skid_pay_n = skid_pay;
        if (flush) begin
            main_v_n = 1'b0;
            skid_v_n = 1'b0;
        end else if (SKID != 0) begin
            if (out_xfer) begin
                if (skid_v) begin
                    main_pay_n = skid_pay;
                    skid_v_n   = 1'b0;
                end else if (in_xfer) begin
                    main_pay_n = new_pay;
                end else begin
                    main_v_n = 1'b0;
                end
            end else if (in_xfer) begin
                if (main_v) begin
                    skid_pay_n = new_pay;
                    skid_v_n   = 1'b1;
                end else begin
                    main_pay_n = new_pay;
                    main_v_n   = 1'b1;
                end
            end
        end else begin
            if (in_xfer) begin
                main_pay_n = new_pay;
                main_v_n   = 1'b1;
            end else if (out_xfer) begin
                main_v_n = 1'b0;
            end
        end
    end

    // in_ready is registered as "skid will be empty" so upstream never sees a combinational path.
    always_ff @(posedge clk) begin
        if (reset) begin
            main_v   <= 1'b0;
            skid_v   <= 1'b0;
            rdy_q    <= 1'b1;
            main_pay <= '0;
            skid_pay <= '0;
        end else begin
            main_v   <= main_v_n;
            skid_v   <= skid_v_n;
            rdy_q    <= !skid_v_n;
            main_pay <= main_pay_n;
            skid_pay <= skid_pay_n;
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Randomised + directed bench for imm_gen_pipe: three instances (64/skid, 64/no-skid, 32/skid)
// share one stimulus set; a queue-based reference model checks the selected instance.
module tb_imm_gen_pipe;

    typedef struct packed {
        logic        err;
        logic [63:0] imm;
        logic [63:0] tgt;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic [31:0] instr;
    logic [2:0]  fmt;
    logic [63:0] pc;

    logic        rdy_a, ov_a, err_a;
    logic        rdy_b, ov_b, err_b;
    logic        rdy_c, ov_c, err_c;
    logic [63:0] imm_a, imm_b;
    logic [31:0] imm_c;
`ifdef IMM_GEN_PC_TARGET_EN
    logic [63:0] tgt_a, tgt_b;
    logic [31:0] tgt_c;
`endif

    int   sel;
    bit   was_reset;
    exp_t sb[$];
    int   nchk = 0;
    int   nerr = 0;

    logic        c_in_ready, c_out_valid, c_err;
    logic [63:0] c_imm, c_tgt;

    always #5 clk = ~clk;

    imm_gen_pipe #(.DATA_W(64), .SKID(1)) dut_a (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy_a),
        .instr(instr), .fmt(fmt),
`ifdef IMM_GEN_PC_TARGET_EN
        .pc(pc), .tgt_out(tgt_a),
`endif
        .out_valid(ov_a), .out_ready(out_ready), .imm_out(imm_a), .imm_err(err_a));

    imm_gen_pipe #(.DATA_W(64), .SKID(0)) dut_b (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy_b),
        .instr(instr), .fmt(fmt),
`ifdef IMM_GEN_PC_TARGET_EN
        .pc(pc), .tgt_out(tgt_b),
`endif
        .out_valid(ov_b), .out_ready(out_ready), .imm_out(imm_b), .imm_err(err_b));

    imm_gen_pipe #(.DATA_W(32), .SKID(1)) dut_c (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy_c),
        .instr(instr), .fmt(fmt),
`ifdef IMM_GEN_PC_TARGET_EN
        .pc(pc), .tgt_out(tgt_c),
`endif
        .out_valid(ov_c), .out_ready(out_ready), .imm_out(imm_c), .imm_err(err_c));

    always_comb begin
        c_tgt = '0;
        case (sel)
            1: begin
                c_in_ready = rdy_b; c_out_valid = ov_b; c_err = err_b; c_imm = imm_b;
`ifdef IMM_GEN_PC_TARGET_EN
                c_tgt = tgt_b;
`endif
            end
            2: begin
                c_in_ready = rdy_c; c_out_valid = ov_c; c_err = err_c; c_imm = 64'(imm_c);
`ifdef IMM_GEN_PC_TARGET_EN
                c_tgt = 64'(tgt_c);
`endif
            end
            default: begin
                c_in_ready = rdy_a; c_out_valid = ov_a; c_err = err_a; c_imm = imm_a;
`ifdef IMM_GEN_PC_TARGET_EN
                c_tgt = tgt_a;
`endif
            end
        endcase
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h (t=%0t sel=%0d)", tag, got, exp, $time, sel);
        end
    endtask

    // Arithmetic statement of the immediate rules, reduced modulo 2^dw.
    function automatic exp_t ref_pay(input logic [31:0] ins, input logic [2:0] f,
                                     input logic [63:0] p, input int dw);
        exp_t   e;
        longint v;
        e.err = 1'b0;
        v = 0;
        case (f)
            3'd0: v = longint'(ins[21:10]) * (ins[22] ? 4096 : 1);
            3'd1: v = longint'($signed(ins[20:12]));
            3'd2: v = longint'($signed(ins[25:0])) * 4;
            3'd3: v = longint'($signed(ins[23:5])) * 4;
            3'd4: begin
                if (dw == 32 && ins[22]) e.err = 1'b1;
                else v = longint'(ins[20:5]) << (16 * int'(ins[22:21]));
            end
            default: e.err = 1'b1;
        endcase
        e.imm = v;
        e.tgt = (f == 3'd2 || f == 3'd3) ? p + e.imm : 64'd0;
        if (dw == 32) begin
            e.imm = e.imm & 64'hFFFF_FFFF;
            e.tgt = e.tgt & 64'hFFFF_FFFF;
        end
        return e;
    endfunction

    // Check current outputs against the model, then account for this cycle's transfers and clock.
    task automatic tick(output bit acc);
        bit   in_x, out_x;
        int   dw;
        exp_t e;
        #1;
        dw = (sel == 2) ? 32 : 64;
        if (sel == 1) check("in_ready", 64'(c_in_ready), 64'(sb.size() == 0 || out_ready));
        else          check("in_ready", 64'(c_in_ready), 64'(sb.size() < 2));
        check("out_valid", 64'(c_out_valid), 64'(sb.size() != 0));
        if (sb.size() != 0) begin
            e = sb[0];
            check("imm_out", c_imm, e.imm);
            check("imm_err", 64'(c_err), 64'(e.err));
`ifdef IMM_GEN_PC_TARGET_EN
            check("tgt_out", c_tgt, e.tgt);
`endif
        end
        if (was_reset) begin
            check("rst_imm", c_imm, 64'd0);
            check("rst_err", 64'(c_err), 64'd0);
`ifdef IMM_GEN_PC_TARGET_EN
            check("rst_tgt", c_tgt, 64'd0);
`endif
        end
        in_x  = in_valid && c_in_ready;
        out_x = c_out_valid && out_ready;
        acc   = in_x && !flush && !reset;
        was_reset = reset;
        if (reset || flush) begin
            sb.delete();
        end else begin
            if (out_x && sb.size() != 0) void'(sb.pop_front());
            if (in_x) sb.push_back(ref_pay(instr, fmt, pc, dw));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic start_phase(input int s);
        sel = s;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb.delete();
        was_reset = 1'b1;
    endtask

    task automatic lit(input string tag, input logic [31:0] ins, input logic [2:0] f,
                       input logic [63:0] ei, input logic ee);
        bit acc;
        in_valid = 1'b1; instr = ins; fmt = f; out_ready = 1'b1;
        tick(acc);
        check({tag, "_acc"}, 64'(acc), 64'd1);
        in_valid = 1'b0;
        #1;
        check({tag, "_valid"}, 64'(c_out_valid), 64'd1);
        check(tag, c_imm, ei);
        check({tag, "_err"}, 64'(c_err), 64'(ee));
        tick(acc);
    endtask

    initial begin
        bit          acc;
        int          idx;
        logic [31:0] sk[3];
        sk[0] = 32'h0000_0040; sk[1] = 32'h0000_0080; sk[2] = 32'h0300_00C0;
        instr = '0; fmt = '0; pc = 64'h0000_0000_0040_0000;

        // Directed formats at DATA_W=64 with skid
        start_phase(0);
        lit("cb_neg",  32'h00FF_FFE0, 3'd3, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
        lit("b_one",   32'h0000_0001, 3'd2, 64'h0000_0000_0000_0004, 1'b0);
        lit("b_min",   32'h0200_0000, 3'd2, 64'hFFFF_FFFF_F800_0000, 1'b0);
        lit("iw_hw3",  32'h0075_79A0, 3'd4, 64'hABCD_0000_0000_0000, 1'b0);
        lit("fmt6",    32'hDEAD_BEEF, 3'd6, 64'd0, 1'b1);
        lit("i_sh12",  32'h007F_FC00, 3'd0, 64'h0000_0000_00FF_F000, 1'b0);
        lit("d_neg",   32'h0010_0000, 3'd1, 64'hFFFF_FFFF_FFFF_FF00, 1'b0);

        // Skid fill: two accepted while stalled, third held upstream, then drained in order
        fmt = 3'd2; out_ready = 1'b0; idx = 0;
        for (int c = 0; c < 4; c++) begin
            in_valid = (idx < 3); instr = sk[(idx < 3) ? idx : 0];
            tick(acc);
            if (acc) idx++;
        end
        check("skid_accepted", 64'(idx), 64'd2);
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            in_valid = (idx < 3); instr = sk[(idx < 3) ? idx : 0];
            tick(acc);
            if (acc) idx++;
        end
        check("skid_drained", 64'(idx), 64'd3);
        in_valid = 1'b0;
        tick(acc);

        // Flush with two entries held and a live input
        out_ready = 1'b0; in_valid = 1'b1;
        for (int c = 0; c < 2; c++) begin instr = 32'h0000_1000 + 32'(c); tick(acc); end
        flush = 1'b1; instr = 32'h00AB_CDE0; fmt = 3'd3;
        tick(acc);
        flush = 1'b0; in_valid = 1'b0;
        #1;
        check("flush_valid", 64'(ov_a), 64'd0);
        check("flush_ready", 64'(rdy_a), 64'd1);
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) tick(acc);

        // Reset mid-stall
        out_ready = 1'b0; in_valid = 1'b1; fmt = 3'd2;
        for (int c = 0; c < 2; c++) begin instr = 32'h03FF_FFF0 - 32'(c); tick(acc); end
        reset = 1'b1;
        tick(acc);
        reset = 1'b0; in_valid = 1'b0;
        #1;
        check("rst_ready", 64'(rdy_a), 64'd1);
        check("rst_imm_lit", imm_a, 64'd0);
        tick(acc);

        // IW out of range at DATA_W=32
        start_phase(2);
        lit("iw32_err", 32'h0075_79A0, 3'd4, 64'd0, 1'b1);
        lit("iw32_hw1", 32'h0035_79A0, 3'd4, 64'h0000_0000_ABCD_0000, 1'b0);

        // No-skid back-to-back: one output per cycle
        start_phase(1);
        out_ready = 1'b1; idx = 0; fmt = 3'd0;
        for (int c = 0; c < 8; c++) begin
            in_valid = 1'b1; instr = 32'h0000_0400 * 32'(c + 1);
            tick(acc);
            if (acc) idx++;
        end
        check("b2b_accepted", 64'(idx), 64'd8);
        in_valid = 1'b0;
        tick(acc);

        // Random streams on each instance
        for (int s = 0; s < 3; s++) begin
            start_phase(s);
            for (int c = 0; c < 400; c++) begin
                in_valid  = ($urandom_range(0, 3) != 0);
                instr     = $urandom;
                fmt       = 3'($urandom_range(0, 7));
                pc        = {$urandom, $urandom};
                out_ready = ($urandom_range(0, 2) != 0);
                flush     = ($urandom_range(0, 50) == 0);
                tick(acc);
            end
            flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
            for (int c = 0; c < 4; c++) tick(acc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
        $finish;
    end

endmodule
